score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 187 ++++++++++++++++++
 tb/tb_score_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//
// Four-slot time-multiplexed seven-segment driver for the score and lives.
// Slot order is 0 = units, 1 = tens, 2 = spacer (always dark), 3 = life.
// A refresh counter produces one tick every REFRESH_DIV clocks. On each tick
// the anode, segment and decimal-point registers are loaded for the slot that
// is current, and the slot index then advances. All outputs are therefore
// registered and change only on tick edges.
//
// The tens and life values are captured into snapshot registers on the tick
// that drives slot 0. Slots 1 and 3 show the snapshot, so one frame never
// mixes an old tens value with a new life value. Slot 0 decodes the live
// units value at its tick.
//
// Optional feature (macro SCORE_DISPLAY_BLINK_EN): a blink counter toggles a
// phase bit every BLINK_DIV clocks. While the life snapshot is 0 and the phase
// bit is 1, every anode is forced off so the game-over display flashes.
// Without the macro no blink logic is built and life 0 shows a steady "0".
//
// Parameters
//   REFRESH_DIV   clocks per digit slot (minimum 2)
//   BLINK_DIV     clocks per blink half-period (blink build only)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   units_counter  BCD units digit of the score
//   tens_counter   BCD tens digit of the score
//   life           remaining lives, 0..7
//   an             digit anodes, active low: [0]=units [1]=tens [2]=spacer [3]=life
//   seg            segments {g,f,e,d,c,b,a}, active low
//   dp             decimal point, active low (lit only in the life slot)
// -----------------------------------------------------------------------------
module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] units_counter,
    input  logic [3:0] tens_counter,
    input  logic [2:0] life,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int REFRESH_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Reject configurations the counters cannot represent.
    if (REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
        $error("score_display: REFRESH_DIV must be >= 2 and BLINK_DIV >= 1");
    end

    // Active-low glyphs; anything above 9 is shown as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

    logic [REFRESH_W-1:0] refresh_cnt_reg, refresh_cnt_next;
    logic [1:0]           idx_reg, idx_next;
    logic [3:0]           tens_snap_reg, tens_snap_next;
    logic [2:0]           life_snap_reg, life_snap_next;
    logic [3:0]           an_reg, an_next;
    logic [6:0]           seg_reg, seg_next;
    logic                 dp_reg, dp_next;
    logic                 tick;
    logic [3:0]           slot_an;

    assign tick = (refresh_cnt_reg == REFRESH_LAST);

    // One-hot-low anode pattern selecting the current slot.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_slot_an
        assign slot_an[gi] = (idx_reg != 2'(gi));
    end

    always_comb begin
        refresh_cnt_next = tick ? '0 : refresh_cnt_reg + 1'b1;
        idx_next         = tick ? idx_reg + 2'd1 : idx_reg;
        tens_snap_next   = tens_snap_reg;
        life_snap_next   = life_snap_reg;
        an_next          = an_reg;
        seg_next         = seg_reg;
        dp_next          = dp_reg;

        if (tick) begin
            an_next  = 4'b1111;
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
            case (idx_reg)
                2'd0: begin
                    an_next        = slot_an;
                    seg_next       = seg_decode(units_counter);
                    tens_snap_next = tens_counter;
                    life_snap_next = life;
                end
                2'd1: begin
                    // Leading-zero blanking: a zero tens digit stays dark.
                    if (tens_snap_reg != 4'd0) begin
                        an_next  = slot_an;
                        seg_next = seg_decode(tens_snap_reg);
                    end
                end
                2'd3: begin
                    an_next  = slot_an;
                    seg_next = seg_decode({1'b0, life_snap_reg});
                    dp_next  = 1'b0;
                end
                default: begin
                    // Spacer slot keeps the defaults: everything dark.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_reg <= '0;
            idx_reg         <= 2'd0;
            tens_snap_reg   <= 4'd0;
            life_snap_reg   <= 3'd0;
            an_reg          <= 4'b1111;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
        end else begin
            refresh_cnt_reg <= refresh_cnt_next;
            idx_reg         <= idx_next;
            tens_snap_reg   <= tens_snap_next;
            life_snap_reg   <= life_snap_next;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               phase_reg;
    logic               blink_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Gating sits after the anode register so the flash follows the phase
    // bit directly instead of waiting for the next slot tick.
    assign blink_off = (life_snap_reg == 3'd0) && phase_reg;
    assign an        = an_reg | {4{blink_off}};
`else
    assign an = an_reg;
`endif

endmodule

// File: tb/tb_score_display.sv
// -----------------------------------------------------------------------------
// tb_score_display
//
// Directed bench for score_display with REFRESH_DIV=4 and BLINK_DIV=16.
// Outputs are sampled on the falling clock edge; each slot lasts four clocks.
// Expected glyphs are written out by hand as active-low {g,f,e,d,c,b,a}.
// -----------------------------------------------------------------------------
module tb_score_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] units_counter;
    logic [3:0] tens_counter;
    logic [2:0] life;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [6:0] G_BLANK = 7'b1111111;

    score_display #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .units_counter (units_counter),
        .tens_counter  (tens_counter),
        .life          (life),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Checks one slot for its four clocks; returns on the first falling edge
    // of the following slot.
    task automatic expect_slot(input string tag, input logic [3:0] ea,
                               input logic [6:0] es, input logic ed);
        $display("[TB] %s an=%b seg=%b dp=%b (want %b/%b/%b)", tag, an, seg, dp, ea, es, ed);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s[%0d]", tag, i), {20'd0, an, seg, dp}, {20'd0, ea, es, ed});
            @(negedge clk);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [6:0] s0, input logic s1_on,
                                input logic [6:0] s1, input logic [6:0] s3);
        expect_slot({tag, "_s0"}, 4'b1110, s0, 1'b1);
        expect_slot({tag, "_s1"}, s1_on ? 4'b1101 : 4'b1111, s1_on ? s1 : G_BLANK, 1'b1);
        expect_slot({tag, "_s2"}, 4'b1111, G_BLANK, 1'b1);
        expect_slot({tag, "_s3"}, 4'b0111, s3, 1'b0);
    endtask

    task automatic skip_frame();
        repeat (16) @(negedge clk);
    endtask

    // Called on the falling edge at which rst was released.
    task automatic measure_first_tick(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an == 4'b1111 && n < 20);
        $display("[TB] %s first anode change after %0d clocks", tag, n);
        check({tag, "_latency"}, n, 4);
        check({tag, "_first_an"}, {28'd0, an}, {28'd0, 4'b1110});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        units_counter = 4'd5;
        tens_counter  = 4'd3;
        life          = 3'd2;

        // Reset held for three clocks: display dark throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold[%0d]", i), {20'd0, an, seg, dp}, {20'd0, 4'b1111, G_BLANK, 1'b1});
        end
        rst = 1'b1;
        measure_first_tick("reset_release");

        // Normal scan, two frames: units 5, tens 3, life 2.
        expect_frame("scan_a", 7'b0010010, 1'b1, 7'b0110000, 7'b0100100);
        expect_frame("scan_b", 7'b0010010, 1'b1, 7'b0110000, 7'b0100100);

        // Leading-zero blanking.
        units_counter = 4'd7;
        tens_counter  = 4'd0;
        skip_frame();
        expect_frame("blank", 7'b1111000, 1'b0, G_BLANK, 7'b0100100);

        // Snapshot: tens/life changed during slot 2 must not reach slot 3.
        units_counter = 4'd1;
        tens_counter  = 4'd3;
        life          = 3'd5;
        skip_frame();
        expect_slot("snap_s0", 4'b1110, 7'b1111001, 1'b1);
        expect_slot("snap_s1", 4'b1101, 7'b0110000, 1'b1);
        tens_counter = 4'd4;
        life         = 3'd6;
        expect_slot("snap_s2", 4'b1111, G_BLANK, 1'b1);
        expect_slot("snap_s3_old", 4'b0111, 7'b0010010, 1'b0);
        // New snapshot taken; further changes mid-frame must not show yet.
        units_counter = 4'd8;
        tens_counter  = 4'd9;
        expect_slot("snap2_s0_hold", 4'b1110, 7'b1111001, 1'b1);
        expect_slot("snap2_s1_new", 4'b1101, 7'b0011001, 1'b1);
        expect_slot("snap2_s2", 4'b1111, G_BLANK, 1'b1);
        expect_slot("snap2_s3_new", 4'b0111, 7'b0000010, 1'b0);
        expect_frame("snap3", 7'b0000000, 1'b1, 7'b0010000, 7'b0000010);

        // Out-of-range BCD shows a dash.
        units_counter = 4'hC;
        tens_counter  = 4'hA;
        life          = 3'd7;
        skip_frame();
        expect_frame("invalid", 7'b0111111, 1'b1, 7'b0111111, 7'b1111000);

        // Game over: life 0.
        units_counter = 4'd0;
        tens_counter  = 4'd1;
        life          = 3'd0;
        skip_frame();
`ifdef SCORE_DISPLAY_BLINK_EN
        begin
            int dark = 0;
            for (int i = 0; i < 32; i++) begin
                if (an == 4'b1111) dark++;
                if (an == 4'b0111)
                    check($sformatf("blink_life_glyph[%0d]", i), {25'd0, seg}, {25'd0, 7'b1000000});
                @(negedge clk);
            end
            $display("[TB] blink: %0d dark clocks out of 32", dark);
            // 16 blanked clocks plus the 4-clock spacer of the lit half.
            check("blink_dark_count", dark, 20);
        end
`else
        expect_frame("life0", 7'b1000000, 1'b1, 7'b1111001, 7'b1000000);
`endif

        // Asynchronous reset in the middle of a lit slot.
        life = 3'd3;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_now", {20'd0, an, seg, dp}, {20'd0, 4'b1111, G_BLANK, 1'b1});
        @(negedge clk);
        check("async_reset_hold", {20'd0, an, seg, dp}, {20'd0, 4'b1111, G_BLANK, 1'b1});
        rst = 1'b1;
        measure_first_tick("rereset_release");
        expect_frame("after_reset", 7'b1000000, 1'b1, 7'b1111001, 7'b0110000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
